// File: rtl/zoom_gain_ctrl.sv
// rtl/zoom_gain_ctrl.sv - frame-synchronous automatic gain controller for the FFT zoom stage
// Optional macro ZOOM_GAIN_SMOOTH_EN: automatic gains are averaged with the committed gain.
module zoom_gain_ctrl #(
   parameter logic [15:0] TARGET_PEAK = 16'd16384,
   parameter logic [31:0] GAIN_MIN    = 32'h0000_1000,
   parameter logic [31:0] GAIN_MAX    = 32'h0100_0000,
   parameter logic [7:0]  ZOOM_MODE   = 8'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_enable,
   input  logic        i_manual,
   input  logic [31:0] i_manual_gain,
   input  logic [15:0] i_rotate_I_data,
   input  logic [15:0] i_rotate_Q_data,
   input  logic        i_rotate_valid,
   input  logic        i_rotate_last,
   output logic [7:0]  o_mode,
   output logic [31:0] o_zoom_data,
   output logic        o_gain_update,
   output logic        o_busy,
   output logic [15:0] o_peak,
   output logic [15:0] o_frame_cnt
);
   typedef enum logic [2:0] {IDLE, CALC, CLAMP, WAIT_BND, COMMIT} state_t;
   state_t state, state_nxt;

   logic [15:0] acc, mag_i, mag_q, mag, snap;
   logic        in_frame, snap_pend, snap_clr, commit;
   logic [15:0] divisor, rem, rem_nxt;
   logic [16:0] rem_sh;
   logic        q_bit;
   logic [31:0] quo, clamped, pending, commit_val;
   logic [4:0]  cnt;

   function automatic logic [15:0] sat_abs(input logic [15:0] x);
      if (!x[15])
         return x;
      else if (x == 16'h8000)
         return 16'h7fff;
      else
         return ~x + 16'd1;
   endfunction

   assign mag_i = sat_abs(i_rotate_I_data);
   assign mag_q = sat_abs(i_rotate_Q_data);
   assign mag   = (mag_i > mag_q) ? mag_i : mag_q;
   assign snap  = (acc > mag) ? acc : mag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc         <= '0;
         in_frame    <= 1'b0;
         o_peak      <= '0;
         o_frame_cnt <= '0;
      end else if (i_rotate_valid) begin
         if (i_rotate_last) begin
            o_peak      <= snap;
            o_frame_cnt <= o_frame_cnt + 16'd1;
            acc         <= '0;
            in_frame    <= 1'b0;
         end else begin
            acc         <= snap;
            in_frame    <= 1'b1;
         end
      end
   end

   // a new snapshot wins over the FSM's clear so the latest frame is never lost
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         snap_pend <= 1'b0;
      else if (i_rotate_valid && i_rotate_last)
         snap_pend <= 1'b1;
      else if (snap_clr)
         snap_pend <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      snap_clr  = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (snap_pend) begin
               snap_clr = 1'b1;
               if (i_manual)
                  state_nxt = WAIT_BND;
               else if (o_peak == 16'd0)
                  state_nxt = CLAMP;
               else
                  state_nxt = CALC;
            end
         end
         CALC:     if (cnt == 5'd31) state_nxt = CLAMP;
         CLAMP:    state_nxt = WAIT_BND;
         WAIT_BND: begin
            if ((i_rotate_valid && i_rotate_last) || (!in_frame && !i_rotate_valid)) begin
               commit    = 1'b1;
               state_nxt = COMMIT;
            end
         end
         COMMIT:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // restoring divide: dividend bits shift out of quo as quotient bits shift in
   assign rem_sh  = {rem, quo[31]};
   assign q_bit   = (rem_sh >= {1'b0, divisor});
   assign rem_nxt = q_bit ? 16'(rem_sh - {1'b0, divisor}) : rem_sh[15:0];
   assign clamped = (quo < GAIN_MIN) ? GAIN_MIN : ((quo > GAIN_MAX) ? GAIN_MAX : quo);

`ifdef ZOOM_GAIN_SMOOTH_EN
   logic        pend_manual;
   logic [32:0] gain_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pend_manual <= 1'b0;
      else if (state == IDLE && snap_pend)
         pend_manual <= i_manual;
   end

   assign gain_sum   = {1'b0, o_zoom_data} + {1'b0, pending};
   assign commit_val = pend_manual ? pending : 32'(gain_sum >> 1);
`else
   assign commit_val = pending;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divisor       <= '0;
         rem           <= '0;
         quo           <= '0;
         cnt           <= '0;
         pending       <= '0;
         o_zoom_data   <= 32'h0001_0000;
         o_gain_update <= 1'b0;
         o_mode        <= '0;
      end else begin
         o_mode        <= i_enable ? ZOOM_MODE : 8'd0;
         o_gain_update <= commit;
         case (state)
            IDLE: begin
               if (snap_pend) begin
                  divisor <= o_peak;
                  rem     <= '0;
                  cnt     <= '0;
                  quo     <= (o_peak == 16'd0) ? GAIN_MAX : {TARGET_PEAK, 16'h0000};
                  if (i_manual)
                     pending <= i_manual_gain;
               end
            end
            CALC: begin
               rem <= rem_nxt;
               quo <= {quo[30:0], q_bit};
               cnt <= cnt + 5'd1;
            end
            CLAMP:    pending <= clamped;
            WAIT_BND: if (commit) o_zoom_data <= commit_val;
            default:  ;
         endcase
      end
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_zoom_gain_ctrl.sv
// tb/tb_zoom_gain_ctrl.sv - scoreboard bench for zoom_gain_ctrl against a frame-level gain model
// Honours ZOOM_GAIN_SMOOTH_EN in the reference model.
module tb_zoom_gain_ctrl;
   localparam logic [15:0] TGT   = 16'd16384;
   localparam logic [31:0] GMIN  = 32'h0000_1000;
   localparam logic [31:0] GMAX  = 32'h0100_0000;
   localparam logic [15:0] TGT2  = 16'd1024;
   localparam logic [31:0] GMIN2 = 32'h0000_0400;
   localparam logic [31:0] UNITY = 32'h0001_0000;

   logic        clk = 1'b0, rst_n = 1'b0, i_enable = 1'b0, i_manual = 1'b0;
   logic [31:0] i_manual_gain = '0;
   logic [15:0] d_i = '0, d_q = '0;
   logic        v = 1'b0, l = 1'b0;

   logic [7:0]  o_mode, d2_mode;
   logic [31:0] o_zoom_data, d2_zoom;
   logic        o_gain_update, o_busy, d2_upd, d2_busy;
   logic [15:0] o_peak, o_frame_cnt, d2_peak, d2_cnt;

   zoom_gain_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_manual(i_manual),
      .i_manual_gain(i_manual_gain), .i_rotate_I_data(d_i), .i_rotate_Q_data(d_q),
      .i_rotate_valid(v), .i_rotate_last(l), .o_mode(o_mode), .o_zoom_data(o_zoom_data),
      .o_gain_update(o_gain_update), .o_busy(o_busy), .o_peak(o_peak), .o_frame_cnt(o_frame_cnt));

   zoom_gain_ctrl #(.TARGET_PEAK(TGT2), .GAIN_MIN(GMIN2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_manual(i_manual),
      .i_manual_gain(i_manual_gain), .i_rotate_I_data(d_i), .i_rotate_Q_data(d_q),
      .i_rotate_valid(v), .i_rotate_last(l), .o_mode(d2_mode), .o_zoom_data(d2_zoom),
      .o_gain_update(d2_upd), .o_busy(d2_busy), .o_peak(d2_peak), .o_frame_cnt(d2_cnt));

   always #5 clk = ~clk;

   typedef struct {logic [31:0] gain; bit manual;} exp_t;
   exp_t        sb_q[$];
   logic [31:0] mon_cur = UNITY;
   int          checks = 0, errors = 0;
   int          peak_acc = 0, frame_cnt_m = 0, last_peak = 0;

   function automatic int mag_of(input logic [15:0] x);
      int s = $signed(x);
      int a = (s < 0) ? -s : s;
      return (a > 32767) ? 32767 : a;
   endfunction

   function automatic logic [31:0] auto_gain(input int peak, input int target,
                                             input logic [31:0] gmin, input logic [31:0] gmax);
      longint q;
      if (peak == 0) return gmax;
      q = (longint'(target) * 65536) / peak;
      if (q < longint'(gmin)) q = longint'(gmin);
      if (q > longint'(gmax)) q = longint'(gmax);
      return q[31:0];
   endfunction

   function automatic logic [31:0] apply(input logic [31:0] cur, input exp_t e);
`ifdef ZOOM_GAIN_SMOOTH_EN
      if (!e.manual) return 32'(({1'b0, cur} + {1'b0, e.gain}) >> 1);
`endif
      return e.gain;
   endfunction

   function automatic logic [15:0] rnd(input int amp);
      int r = int'($urandom_range(0, 2 * amp)) - amp;
      return 16'(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      v = 1'b0; l = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_beat(input logic [15:0] di, input logic [15:0] dq, input logic last);
      d_i = di; d_q = dq; v = 1'b1; l = last;
      if (mag_of(di) > peak_acc) peak_acc = mag_of(di);
      if (mag_of(dq) > peak_acc) peak_acc = mag_of(dq);
      @(posedge clk); #1;
      if (last) begin
         frame_cnt_m++;
         chk("o_peak", {16'h0, o_peak}, peak_acc);
         chk("d2_peak", {16'h0, d2_peak}, peak_acc);
         chk("o_frame_cnt", {16'h0, o_frame_cnt}, frame_cnt_m);
         sb_q.push_back('{gain: (i_manual ? i_manual_gain : auto_gain(peak_acc, TGT, GMIN, GMAX)),
                          manual: i_manual});
         last_peak = peak_acc;
         peak_acc  = 0;
      end
   endtask

   task automatic send_frame(input int len, input int amp, input bit gaps);
      for (int i = 0; i < len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle(1);
         send_beat(rnd(amp), rnd(amp), i == len - 1);
      end
   endtask

   task automatic settle(input string name);
      idle(100);
      chk({name, "_busy"}, {31'h0, o_busy}, 0);
      chk({name, "_d2_busy"}, {31'h0, d2_busy || d2_upd}, 0);
      chk({name, "_pending_expect"}, sb_q.size(), 0);
   endtask

   // monitor: commit boundary, committed value against the scoreboard, mode latency
   initial begin
      bit prev_v = 0, prev_vl = 0, prev_in = 0, in_fr = 0, prev_en = 0, prev_ok = 0, matched;
      exp_t e;
      logic [31:0] cand, first;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_v = 0; prev_vl = 0; prev_in = 0; in_fr = 0; prev_ok = 0;
         end else begin
            if (prev_ok) chk("o_mode", {24'h0, o_mode}, prev_en ? 32'd4 : 32'd0);
            if (o_gain_update) begin
               checks++;
               if (!(prev_vl || (!prev_v && !prev_in))) begin
                  errors++;
                  $display("FAIL commit_boundary: commit at %0t, previous cycle valid=%0d last=%0d in_frame=%0d",
                           $time, prev_v, prev_vl, prev_in);
               end
               matched = 0;
               first   = 32'hxxxx_xxxx;
               while (sb_q.size() > 0 && !matched) begin
                  e    = sb_q.pop_front();
                  cand = apply(mon_cur, e);
                  if (first === 32'hxxxx_xxxx) first = cand;
                  if (cand == o_zoom_data) matched = 1;
               end
               checks++;
               if (matched) mon_cur = cand;
               else begin
                  errors++;
                  $display("FAIL gain_value: got %h expected %h", o_zoom_data, first);
                  mon_cur = o_zoom_data;
               end
            end
            prev_v  = v;
            prev_vl = v && l;
            prev_in = in_fr;
            if (v) in_fr = !l;
            prev_en = i_enable;
            prev_ok = 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int pulses, at_cyc, p1, p2;
      logic [31:0] d2_exp;
      #12;
      chk("rst_zoom", o_zoom_data, UNITY);
      chk("rst_mode", {24'h0, o_mode}, 0);
      chk("rst_flags", {30'h0, o_gain_update, o_busy}, 0);
      chk("rst_peak", {16'h0, o_peak}, 0);
      chk("rst_cnt", {16'h0, o_frame_cnt}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      i_enable = 1'b1;
      idle(2);

      // 64-beat frame with peak 8192, then exact commit latency
      for (int i = 0; i < 64; i++)
         send_beat((i == 20) ? 16'd8192 : rnd(8191), rnd(8191), i == 63);
      p1 = last_peak;
      v = 1'b0; l = 1'b0;
      pulses = 0; at_cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (o_gain_update) begin
            pulses++;
            if (at_cyc < 0) at_cyc = c;
         end
      end
      chk("commit_latency", at_cyc, 35);
      chk("commit_pulses", pulses, 1);
      chk("gain_8192", o_zoom_data, apply(UNITY, '{gain: 32'h0002_0000, manual: 0}));
      settle("t1");

      // saturating -32768 beat
      for (int i = 0; i < 20; i++)
         send_beat((i == 7) ? 16'h8000 : rnd(30000), rnd(30000), i == 19);
      p2 = last_peak;
      settle("t2");
      d2_exp = apply(apply(UNITY, '{gain: auto_gain(p1, TGT2, GMIN2, GMAX), manual: 0}),
                     '{gain: auto_gain(p2, TGT2, GMIN2, GMAX), manual: 0});
      chk("d2_unclamped", d2_zoom, d2_exp);

      // all-zero frame and a tiny peak clamp to GAIN_MAX
      send_frame(8, 0, 0);
      settle("t3");
      for (int i = 0; i < 12; i++)
         send_beat((i == 3) ? 16'd20 : rnd(19), rnd(19), i == 11);
      settle("t4");

      // back-to-back 16-beat frames
      for (int f = 0; f < 6; f++)
         send_frame(16, (f % 3 == 0) ? 32767 : ((f % 3 == 1) ? 5000 : 300), 0);
      settle("t5");

      // manual gain while a frame is in progress
      i_manual = 1'b1;
      i_manual_gain = 32'h0003_0000;
      send_frame(16, 1000, 0);
      for (int i = 0; i < 40; i++)
         send_beat(rnd(1000), rnd(1000), i == 39);
      chk("manual_commit_pulse", {31'h0, o_gain_update}, 1);
      chk("manual_commit_gain", o_zoom_data, 32'h0003_0000);
      settle("t6");
      i_manual = 1'b0;

      // mode latency
      i_enable = 1'b0;
      idle(2);
      chk("mode_off", {24'h0, o_mode}, 0);
      i_enable = 1'b1;
      chk("mode_same_cycle", {24'h0, o_mode}, 0);
      idle(1);
      chk("mode_on", {24'h0, o_mode}, 4);
      chk("d2_mode_on", {24'h0, d2_mode}, 4);

      // randomized frames with gaps, enable toggling and overlapping snapshots
      for (int f = 0; f < 12; f++) begin
         i_enable = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) send_beat(16'h8000, rnd(100), 1'b0);
         send_frame($urandom_range(1, 24), 32767 >> $urandom_range(0, 14), 1);
         idle($urandom_range(0, 45));
      end
      i_enable = 1'b1;
      settle("t7");

      // reset during the divide
      send_frame(16, 4000, 0);
      idle(10);
      chk("calc_busy", {31'h0, o_busy}, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_zoom", o_zoom_data, UNITY);
      chk("rstmid_flags", {30'h0, o_gain_update, o_busy}, 0);
      chk("rstmid_peak_cnt", {o_peak, o_frame_cnt}, 0);
      chk("rstmid_mode", {24'h0, o_mode}, 0);
      sb_q.delete();
      mon_cur = UNITY;
      frame_cnt_m = 0;
      peak_acc = 0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      send_frame(24, 12000, 0);
      settle("t8");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
